// File: rtl/gemm_tile_scheduler.sv
// GEMM tile sequencer: splits an M x K by K x N job into ARRAY_ROW x ARRAY_COL output
// tiles and runs one start/done handshake per tile with the tile compute controller.
module gemm_tile_scheduler #(
    parameter int ARRAY_ROW = 8,
    parameter int ARRAY_COL = 8,
    parameter int DIM_W     = 16,
    parameter int ADDR_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ap_start,
    input  logic [DIM_W-1:0]     cfg_m_dim,
    input  logic [DIM_W-1:0]     cfg_n_dim,
    input  logic [DIM_W-1:0]     cfg_k_dim,
    output logic                 ap_idle,
    output logic                 ap_done,
    output logic                 cfg_err,
    output logic                 tile_start,
    input  logic                 tile_done,
    output logic [DIM_W-1:0]     tile_m_idx,
    output logic [DIM_W-1:0]     tile_n_idx,
    output logic [DIM_W-1:0]     tile_rows_valid,
    output logic [DIM_W-1:0]     tile_cols_valid,
    output logic [DIM_W-1:0]     tile_k_dim,
    output logic [ADDR_W-1:0]    tile_w_base,
    output logic [ADDR_W-1:0]    tile_x_base,
    output logic [ADDR_W-1:0]    tile_y_base,
    output logic [2*DIM_W-1:0]   tiles_completed
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [DIM_W-1:0]  ROW_D = DIM_W'(ARRAY_ROW);
    localparam logic [DIM_W-1:0]  COL_D = DIM_W'(ARRAY_COL);
    localparam logic [ADDR_W-1:0] ROW_A = ADDR_W'(ARRAY_ROW);
    localparam logic [ADDR_W-1:0] COL_A = ADDR_W'(ARRAY_COL);

    logic [2:0]          state;
    logic [DIM_W-1:0]    m_lat;
    logic [DIM_W-1:0]    n_lat;
    logic [DIM_W-1:0]    k_lat;
    logic [DIM_W-1:0]    m_idx;
    logic [DIM_W-1:0]    n_idx;
    logic [DIM_W-1:0]    rows_rem;
    logic [DIM_W-1:0]    cols_rem;
    logic [ADDR_W-1:0]   x_base;
    logic [ADDR_W-1:0]   w_base;
    logic [ADDR_W-1:0]   y_base;
    logic [ADDR_W-1:0]   y_row_base;
    logic [2*DIM_W-1:0]  tile_cnt;
    logic                err;
    logic                armed;

    logic                last_m;
    logic                last_n;
    logic [ADDR_W-1:0]   x_step;
    logic [ADDR_W-1:0]   w_step;
    logic [ADDR_W-1:0]   y_step;

    // Step sizes are constant-coefficient products of latched dimensions.
    assign x_step = ADDR_W'(k_lat) * ROW_A;
    assign w_step = ADDR_W'(k_lat) * COL_A;
    assign y_step = ADDR_W'(n_lat) * ROW_A;

    assign last_m = (rows_rem <= ROW_D);
    assign last_n = (cols_rem <= COL_D);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            m_lat      <= '0;
            n_lat      <= '0;
            k_lat      <= '0;
            m_idx      <= '0;
            n_idx      <= '0;
            rows_rem   <= '0;
            cols_rem   <= '0;
            x_base     <= '0;
            w_base     <= '0;
            y_base     <= '0;
            y_row_base <= '0;
            tile_cnt   <= '0;
            err        <= 1'b0;
            armed      <= 1'b0;
        end else begin
            // After reset a job only starts once ap_start has been seen low.
            if (!ap_start) begin
                armed <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (ap_start && armed) begin
                        m_lat      <= cfg_m_dim;
                        n_lat      <= cfg_n_dim;
                        k_lat      <= cfg_k_dim;
                        rows_rem   <= cfg_m_dim;
                        cols_rem   <= cfg_n_dim;
                        m_idx      <= '0;
                        n_idx      <= '0;
                        x_base     <= '0;
                        w_base     <= '0;
                        y_base     <= '0;
                        y_row_base <= '0;
                        tile_cnt   <= '0;
                        state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (m_lat == '0 || n_lat == '0 || k_lat == '0) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (tile_done) begin
                        tile_cnt <= tile_cnt + 1'b1;
                        state    <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (!last_m) begin
                        m_idx    <= m_idx + 1'b1;
                        rows_rem <= rows_rem - ROW_D;
                        x_base   <= x_base + x_step;
                        y_base   <= y_base + y_step;
                        state    <= S_ISSUE;
                    end else if (!last_n) begin
                        m_idx      <= '0;
                        n_idx      <= n_idx + 1'b1;
                        rows_rem   <= m_lat;
                        cols_rem   <= cols_rem - COL_D;
                        x_base     <= '0;
                        w_base     <= w_base + w_step;
                        y_row_base <= y_row_base + COL_A;
                        y_base     <= y_row_base + COL_A;
                        state      <= S_ISSUE;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!ap_start) begin
                        err   <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign ap_idle         = (state == S_IDLE);
    assign ap_done         = (state == S_DONE);
    assign tile_start      = (state == S_ISSUE);
    assign cfg_err         = err;
    assign tile_m_idx      = m_idx;
    assign tile_n_idx      = n_idx;
    assign tile_rows_valid = last_m ? rows_rem : ROW_D;
    assign tile_cols_valid = last_n ? cols_rem : COL_D;
    assign tile_k_dim      = k_lat;
    assign tile_w_base     = w_base;
    assign tile_x_base     = x_base;
    assign tile_y_base     = y_base;
    assign tiles_completed = tile_cnt;

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Scoreboard bench for gemm_tile_scheduler: a job-level reference model queues the
// expected tile sequence and a monitor checks every tile_start against it.
module tb_gemm_tile_scheduler;

    localparam int AR = 8;
    localparam int AC = 8;
    localparam int DW = 16;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            ap_start;
    logic [DW-1:0]   cfg_m_dim;
    logic [DW-1:0]   cfg_n_dim;
    logic [DW-1:0]   cfg_k_dim;
    logic            ap_idle;
    logic            ap_done;
    logic            cfg_err;
    logic            tile_start;
    logic            tile_done;
    logic [DW-1:0]   tile_m_idx;
    logic [DW-1:0]   tile_n_idx;
    logic [DW-1:0]   tile_rows_valid;
    logic [DW-1:0]   tile_cols_valid;
    logic [DW-1:0]   tile_k_dim;
    logic [AW-1:0]   tile_w_base;
    logic [AW-1:0]   tile_x_base;
    logic [AW-1:0]   tile_y_base;
    logic [2*DW-1:0] tiles_completed;

    gemm_tile_scheduler #(
        .ARRAY_ROW(AR),
        .ARRAY_COL(AC),
        .DIM_W(DW),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ap_start(ap_start),
        .cfg_m_dim(cfg_m_dim),
        .cfg_n_dim(cfg_n_dim),
        .cfg_k_dim(cfg_k_dim),
        .ap_idle(ap_idle),
        .ap_done(ap_done),
        .cfg_err(cfg_err),
        .tile_start(tile_start),
        .tile_done(tile_done),
        .tile_m_idx(tile_m_idx),
        .tile_n_idx(tile_n_idx),
        .tile_rows_valid(tile_rows_valid),
        .tile_cols_valid(tile_cols_valid),
        .tile_k_dim(tile_k_dim),
        .tile_w_base(tile_w_base),
        .tile_x_base(tile_x_base),
        .tile_y_base(tile_y_base),
        .tiles_completed(tiles_completed)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned m_idx;
        int unsigned n_idx;
        int unsigned rows;
        int unsigned cols;
        int unsigned k;
        int unsigned w;
        int unsigned x;
        int unsigned y;
    } tile_t;

    tile_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: tile list built directly from the job definition (n outer, m inner).
    task automatic push_job(input int unsigned m, input int unsigned n, input int unsigned k);
        tile_t e;
        int unsigned rt;
        int unsigned ct;
        if (m == 0 || n == 0 || k == 0) return;
        rt = (m + AR - 1) / AR;
        ct = (n + AC - 1) / AC;
        for (int unsigned nt = 0; nt < ct; nt++) begin
            for (int unsigned mt = 0; mt < rt; mt++) begin
                e.m_idx = mt;
                e.n_idx = nt;
                e.rows  = (m - mt * AR < AR) ? m - mt * AR : AR;
                e.cols  = (n - nt * AC < AC) ? n - nt * AC : AC;
                e.k     = k;
                e.w     = nt * AC * k;
                e.x     = mt * AR * k;
                e.y     = mt * AR * n + nt * AC;
                exp_q.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        tile_t e;
        if (rst === 1'b0 && tile_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tile_start: got tile (%0d,%0d), expected none",
                         tile_m_idx, tile_n_idx);
            end else begin
                e = exp_q.pop_front();
                chk("tile_m_idx", 64'(tile_m_idx), 64'(e.m_idx));
                chk("tile_n_idx", 64'(tile_n_idx), 64'(e.n_idx));
                chk("tile_rows_valid", 64'(tile_rows_valid), 64'(e.rows));
                chk("tile_cols_valid", 64'(tile_cols_valid), 64'(e.cols));
                chk("tile_k_dim", 64'(tile_k_dim), 64'(e.k));
                chk("tile_w_base", 64'(tile_w_base), 64'(e.w));
                chk("tile_x_base", 64'(tile_x_base), 64'(e.x));
                chk("tile_y_base", 64'(tile_y_base), 64'(e.y));
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ap_idle"}, 64'(ap_idle), 64'd1);
        chk({tag, "_ap_done"}, 64'(ap_done), 64'd0);
        chk({tag, "_cfg_err"}, 64'(cfg_err), 64'd0);
        chk({tag, "_tile_start"}, 64'(tile_start), 64'd0);
        chk({tag, "_idx"}, 64'({tile_m_idx, tile_n_idx}), 64'd0);
        chk({tag, "_extents"}, 64'({tile_rows_valid, tile_cols_valid, tile_k_dim}), 64'd0);
        chk({tag, "_bases"}, 64'(tile_w_base | tile_x_base | tile_y_base), 64'd0);
        chk({tag, "_tiles_completed"}, 64'(tiles_completed), 64'd0);
    endtask

    // Called on a negedge where tile_start is expected; recovers within a bounded window.
    task automatic expect_start_now(input string name, output bit ok);
        ok = 1'b1;
        chk(name, 64'(tile_start), 64'd1);
        if (tile_start !== 1'b1) begin
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (tile_start === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                checks++;
                errors++;
                $display("FAIL %s_timeout: got no tile_start in 200 cycles, expected one", name);
            end
        end
    endtask

    task automatic run_job(input int unsigned m, input int unsigned n, input int unsigned k,
                           input int dmin, input int dmax, input bit spur, input int hold,
                           input int rst_tile);
        int unsigned ntiles;
        bit ok;
        ntiles = (m == 0 || n == 0 || k == 0) ? 0 : ((m + AR - 1) / AR) * ((n + AC - 1) / AC);
        push_job(m, n, k);
        @(negedge clk);
        chk("idle_before_job", 64'(ap_idle), 64'd1);
        if (spur) begin
            tile_done = 1'b1;
            @(negedge clk);
            tile_done = 1'b0;
        end
        cfg_m_dim = DW'(m);
        cfg_n_dim = DW'(n);
        cfg_k_dim = DW'(k);
        ap_start  = 1'b1;
        @(negedge clk);
        if (ntiles == 0) begin
            chk("err_done_not_early", 64'(ap_done), 64'd0);
            @(negedge clk);
            chk("err_ap_done", 64'(ap_done), 64'd1);
            chk("err_cfg_err", 64'(cfg_err), 64'd1);
        end else begin
            chk("start_not_early", 64'(tile_start), 64'd0);
            @(negedge clk);
            expect_start_now("first_start_latency", ok);
            if (!ok) begin
                ap_start = 1'b0;
                exp_q.delete();
                return;
            end
            for (int unsigned i = 0; i < ntiles; i++) begin
                cfg_m_dim = DW'($urandom);
                cfg_n_dim = DW'($urandom);
                cfg_k_dim = DW'($urandom);
                tile_done = spur;
                @(negedge clk);
                tile_done = 1'b0;
                if (rst_tile == int'(i)) begin
                    rst = 1'b1;
                    #1;
                    chk_reset_vals("mid_job_reset");
                    exp_q.delete();
                    @(negedge clk);
                    rst = 1'b0;
                    for (int j = 0; j < 10; j++) begin
                        @(negedge clk);
                        chk("no_start_after_reset", 64'(tile_start), 64'd0);
                    end
                    ap_start = 1'b0;
                    return;
                end
                repeat ($urandom_range(dmax, dmin)) @(negedge clk);
                tile_done = 1'b1;
                @(negedge clk);
                tile_done = spur;
                chk("tiles_completed", 64'(tiles_completed), 64'(i + 1));
                chk("start_not_early_next", 64'(tile_start), 64'd0);
                @(negedge clk);
                tile_done = 1'b0;
                if (i + 1 < ntiles) begin
                    expect_start_now("next_start_latency", ok);
                    if (!ok) begin
                        ap_start = 1'b0;
                        exp_q.delete();
                        return;
                    end
                end else begin
                    chk("last_ap_done_latency", 64'(ap_done), 64'd1);
                end
            end
        end
        for (int j = 0; j < hold; j++) begin
            tile_done = spur && (j == 0);
            @(negedge clk);
            chk("done_hold", 64'(ap_done), 64'd1);
        end
        tile_done = 1'b0;
        chk("tiles_completed_final", 64'(tiles_completed), 64'(ntiles));
        chk("cfg_err_final", 64'(cfg_err), 64'(ntiles == 0));
        chk("all_tiles_issued", 64'(exp_q.size()), 64'd0);
        ap_start = 1'b0;
        @(negedge clk);
        chk("back_to_idle", 64'(ap_idle), 64'd1);
        chk("done_cleared", 64'(ap_done), 64'd0);
        chk("cfg_err_cleared", 64'(cfg_err), 64'd0);
        exp_q.delete();
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst       = 1'b1;
        ap_start  = 1'b0;
        tile_done = 1'b0;
        cfg_m_dim = '0;
        cfg_n_dim = '0;
        cfg_k_dim = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        run_job(8, 8, 192, 19, 19, 1'b0, 2, -1);
        run_job(20, 16, 4, 1, 5, 1'b0, 2, -1);
        run_job(0, 8, 8, 1, 1, 1'b0, 3, -1);
        run_job(8, 8, 8, 1, 3, 1'b0, 50, -1);
        run_job(8, 16, 8, 1, 3, 1'b0, 1, -1);
        run_job(20, 16, 4, 2, 6, 1'b1, 3, -1);
        run_job(20, 16, 4, 3, 3, 1'b0, 0, 2);
        run_job(20, 16, 4, 1, 2, 1'b0, 1, -1);
        run_job(17, 9, 0, 1, 1, 1'b0, 2, -1);
        for (int r = 0; r < 25; r++) begin
            run_job($urandom_range(40, 0), $urandom_range(40, 0), $urandom_range(300, 0),
                    1, 6, 1'($urandom), int'($urandom_range(4, 0)), -1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gemm_tile_scheduler.md
Name: gemm_tile_scheduler

Overview:
Top-level GEMM tile sequencer that sits between the PS AXI-Lite register block and the per-tile compute controller, which runs the load-weights, compute, drain sequence for one tile. It takes an M x K by K x N job, splits it into ARRAY_ROW x ARRAY_COL output tiles, and issues one start/done handshake per tile. For each tile it supplies the tile indices, buffer base addresses and valid extents for partial edge tiles. It reports job completion and configuration errors back to the PS.

Parameters:
ARRAY_ROW, 8, systolic array rows (output rows per tile, M direction)
ARRAY_COL, 8, systolic array columns (output columns per tile, N direction)
DIM_W, 16, width of the M/N/K configuration fields and tile indices
ADDR_W, 32, width of the element-granular base addresses

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
ap_start  in  1  level; job request from PS
cfg_m_dim  in  DIM_W  M (rows of X and Y)
cfg_n_dim  in  DIM_W  N (columns of W and Y)
cfg_k_dim  in  DIM_W  K (reduction depth)
ap_idle  out  1  high in IDLE
ap_done  out  1  high in DONE
cfg_err  out  1  job rejected (a dimension was 0); valid while ap_done=1
tile_start  out  1  one-cycle pulse: tile_* outputs valid, tile controller may start
tile_done  in  1  one-cycle pulse from tile controller: current tile finished
tile_m_idx  out  DIM_W  tile row index
tile_n_idx  out  DIM_W  tile column index
tile_rows_valid  out  DIM_W  valid rows in tile, 1..ARRAY_ROW
tile_cols_valid  out  DIM_W  valid columns in tile, 1..ARRAY_COL
tile_k_dim  out  DIM_W  latched K, passed to tile controller
tile_w_base  out  ADDR_W  weight base = n_idx*ARRAY_COL*K
tile_x_base  out  ADDR_W  input base = m_idx*ARRAY_ROW*K
tile_y_base  out  ADDR_W  output base = m_idx*ARRAY_ROW*N + n_idx*ARRAY_COL
tiles_completed  out  DIM_W*2  count of tile_done pulses accepted in the current job

Behaviour:
- Reset:
  - While rst=1: state=IDLE, ap_idle=1, all other outputs 0.
  - Reset asserted in any state, including mid-WAIT, aborts the job immediately. No tile_start is issued after rst deasserts until a new ap_start.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- State machine: IDLE -> CHECK -> ISSUE -> WAIT -> NEXT -> (ISSUE | DONE) -> IDLE.
- IDLE:
  - If ap_start=1, latch cfg_m/n/k_dim.
  - Clear indices, address accumulators and tiles_completed.
  - Go to CHECK.
- CHECK: if any latched dimension is 0, set cfg_err=1 and go to DONE. Otherwise go to ISSUE.
- ISSUE:
  - tile_start=1 for exactly this one cycle; go to WAIT.
  - tile_* outputs are valid from this cycle and stay stable until the next ISSUE.
- WAIT: hold until tile_done=1, then increment tiles_completed and go to NEXT.
- tile_done is ignored in every state except WAIT, including the ISSUE cycle. Spurious pulses do not change any counter.
- NEXT (iteration order: n outer, m inner, so weights are reused across consecutive tiles):
  - If m is not the last row tile: m_idx+1.
  - Else if n is not the last column tile: m_idx=0, n_idx+1.
  - Else: go to DONE.
- Addresses are updated with adders only, no multipliers:
  - x_base += ARRAY_ROW*K and y_base += ARRAY_ROW*N on an m step.
  - On an n wrap: x_base=0, w_base += ARRAY_COL*K, row-start y_base += ARRAY_COL, and y_base = the new row-start value.
  - All address arithmetic is modulo 2^ADDR_W and wraps silently.
- Tile counts: row tiles = ceil(M/ARRAY_ROW), column tiles = ceil(N/ARRAY_COL).
- Edge extents:
  - tile_rows_valid = min(ARRAY_ROW, M - m_idx*ARRAY_ROW).
  - tile_cols_valid = min(ARRAY_COL, N - n_idx*ARRAY_COL).
  - Both are tracked with remaining-row and remaining-column down-counters.
- DONE:
  - ap_done=1 and ap_idle=0.
  - Stay in DONE while ap_start=1; go to IDLE when ap_start=0. Holding ap_start high therefore never retriggers a job.
  - cfg_err clears on the transition to IDLE.
- Latency:
  - ap_start sampled high at cycle c: first tile_start at c+2.
  - tile_done at cycle t: next tile_start at t+2. After the last tile, ap_done=1 from t+2.
  - Config error: ap_done=1 and cfg_err=1 at c+2, and tile_start is never asserted.
- cfg_* inputs are only sampled in IDLE. Changes during a job have no effect.

Test Plan:
1. M=8, N=8, K=192; tile_done returned 20 cycles after each tile_start -> one tile_start with idx (0,0), rows/cols_valid 8/8, all bases 0, tile_k_dim=192; ap_done=1 two cycles after tile_done; tiles_completed=1.
2. M=20, N=16, K=4 -> 6 tiles in order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1):
   - rows_valid 8,8,4 repeating; cols_valid 8 throughout.
   - x_base 0,32,64 repeating; w_base 0,0,0,32,32,32.
   - y_base 0,128,256,8,136,264.
   - tiles_completed=6.
3. M=0, N=8, K=8 -> no tile_start; ap_done=1 and cfg_err=1 at c+2; both clear after ap_start is dropped.
4. Hold ap_start high through DONE for 50 cycles -> no new tile_start, ap_done stays 1. Drop ap_start -> IDLE with ap_idle=1; re-raise ap_start -> a fresh job starts from (0,0).
5. Pulse tile_done in IDLE, in the ISSUE cycle, and twice within one WAIT -> only the first WAIT pulse is counted; tiles_completed increments by exactly 1 per tile.
6. Assert rst during WAIT of tile 3 in the scenario-2 job -> all outputs return to reset values the same cycle; after release, no tile_start until a new ap_start rising, and that job restarts at (0,0) with tiles_completed=0.
